// File: rtl/frame_buffer_loader.sv
// frame_buffer_loader
// Upstream stage of the VGA picture path. It receives a valid/ready byte
// stream, locks onto a two-byte frame header and stores the following DEPTH
// pixel bytes in an internal RAM. The VGA controller reads that RAM through a
// ROM-style port with one cycle of read latency.
//
// Build option:
//   FB_CHECKSUM_EN - when defined, the frame carries one trailing byte that
//                    must equal the mod-256 sum of its pixel bytes. The frame
//                    only counts as good when that byte matches.
module frame_buffer_loader #(
   parameter int         DEPTH   = 4800,
   parameter int         AW      = 13,
   parameter logic [7:0] HDR0    = 8'hA5,
   parameter logic [7:0] HDR1    = 8'h5A,
   parameter int         TIMEOUT = 40000
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data,
   output logic          load_busy,
   output logic          load_done,
   output logic          load_err,
   output logic [7:0]    frame_cnt
);

   localparam int            IW        = $clog2(TIMEOUT + 1);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [AW-1:0] DEPTH_A   = AW'(DEPTH);
   localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_HDR0,
      S_HDR1,
      S_LOAD,
`ifdef FB_CHECKSUM_EN
      S_CHK,
`endif
      S_DONE
   } state_t;

   state_t        state;
   logic [AW-1:0] wr_addr;
   logic [IW-1:0] idle_cnt;
   logic [7:0]    ram [0:DEPTH-1];

   logic          accept;
   logic          wr_en;
   logic          hdr_lock;

   // A byte moves only on a completed handshake; pixel writes happen in S_LOAD only.
   assign accept   = in_valid && in_ready;
   assign wr_en    = accept && (state == S_LOAD);
   assign hdr_lock = accept && (state == S_HDR1) && (in_data == HDR1);

`ifdef FB_CHECKSUM_EN
   logic [7:0] sum;

   // Running mod-256 sum of the pixel bytes, restarted when the header locks.
   always_ff @(posedge clk) begin
      if (hdr_lock) begin
         sum <= 8'h00;
      end else if (wr_en) begin
         sum <= sum + in_data;
      end
   end
`endif

   // Pixel store: one write port from the loader, no reset on contents.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         ram[wr_addr] <= in_data;
      end
   end

   // Read port for the VGA controller: one cycle latency, zero beyond the frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= 8'h00;
      end else if (rd_addr < DEPTH_A) begin
         rd_data <= ram[rd_addr];
      end else begin
         rd_data <= 8'h00;
      end
   end

   // Frame FSM with registered handshake, status and pulse outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_HDR0;
         wr_addr   <= '0;
         idle_cnt  <= '0;
         in_ready  <= 1'b1;
         load_busy <= 1'b0;
         load_done <= 1'b0;
         load_err  <= 1'b0;
         frame_cnt <= 8'h00;
      end else begin
         load_done <= 1'b0;
         load_err  <= 1'b0;
         case (state)
            S_HDR0: begin
               if (accept && (in_data == HDR0)) begin
                  state <= S_HDR1;
               end
            end

            S_HDR1: begin
               if (hdr_lock) begin
                  state     <= S_LOAD;
                  wr_addr   <= '0;
                  idle_cnt  <= '0;
                  load_busy <= 1'b1;
               end else if (accept && (in_data != HDR0)) begin
                  // A repeated first header byte keeps the sync attempt alive.
                  state <= S_HDR0;
               end
            end

            S_LOAD: begin
               if (accept) begin
                  idle_cnt <= '0;
                  if (wr_addr == LAST_ADDR) begin
                     wr_addr <= '0;
`ifdef FB_CHECKSUM_EN
                     state   <= S_CHK;
`else
                     state     <= S_DONE;
                     in_ready  <= 1'b0;
                     load_busy <= 1'b0;
                     load_done <= 1'b1;
                     frame_cnt <= frame_cnt + 8'd1;
`endif
                  end else begin
                     wr_addr <= wr_addr + AW'(1);
                  end
               end else if (idle_cnt == IDLE_MAX) begin
                  // Stalled source: drop the frame, keep what was already written.
                  state     <= S_HDR0;
                  wr_addr   <= '0;
                  idle_cnt  <= '0;
                  load_busy <= 1'b0;
                  load_err  <= 1'b1;
               end else begin
                  idle_cnt <= idle_cnt + IW'(1);
               end
            end

`ifdef FB_CHECKSUM_EN
            S_CHK: begin
               if (accept) begin
                  idle_cnt  <= '0;
                  load_busy <= 1'b0;
                  if (in_data == sum) begin
                     state     <= S_DONE;
                     in_ready  <= 1'b0;
                     load_done <= 1'b1;
                     frame_cnt <= frame_cnt + 8'd1;
                  end else begin
                     state    <= S_HDR0;
                     load_err <= 1'b1;
                  end
               end else if (idle_cnt == IDLE_MAX) begin
                  state     <= S_HDR0;
                  idle_cnt  <= '0;
                  load_busy <= 1'b0;
                  load_err  <= 1'b1;
               end else begin
                  idle_cnt <= idle_cnt + IW'(1);
               end
            end
`endif

            S_DONE: begin
               // Single-cycle pause so the completion pulse is not overlapped by new input.
               state    <= S_HDR0;
               in_ready <= 1'b1;
            end

            default: begin
               state     <= S_HDR0;
               in_ready  <= 1'b1;
               load_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frame_buffer_loader.sv
// tb_frame_buffer_loader
// Drives header/pixel byte streams with random gaps and random read addresses,
// and compares every output each cycle with a byte-level reference model.
`timescale 1ns/1ps
module tb_frame_buffer_loader;

   localparam int DEPTH = 4800;
   localparam int AW    = 13;
   localparam int TMO   = 300;

   localparam int PH_HUNT = 0;
   localparam int PH_SYNC = 1;
   localparam int PH_PIX  = 2;
   localparam int PH_SUM  = 3;
   localparam int PH_DONE = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [7:0]    in_data = 8'h00;
   logic          in_ready;
   logic [AW-1:0] rd_addr = '0;
   logic [7:0]    rd_data;
   logic          load_busy;
   logic          load_done;
   logic          load_err;
   logic [7:0]    frame_cnt;

   frame_buffer_loader #(
      .DEPTH  (DEPTH),
      .AW     (AW),
      .HDR0   (8'hA5),
      .HDR1   (8'h5A),
      .TIMEOUT(TMO)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .load_busy(load_busy),
      .load_done(load_done),
      .load_err (load_err),
      .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] mram [DEPTH];
   bit         mknown [DEPTH];
   int         m_phase = PH_HUNT;
   int         npix = 0;
   int         m_idle = 0;
   logic [7:0] m_sum = 8'h00;
   logic       m_ready = 1'b1;
   logic       m_busy = 1'b0;
   logic       m_done = 1'b0;
   logic       m_err = 1'b0;
   logic [7:0] m_cnt = 8'h00;
   logic [7:0] m_rd = 8'h00;
   bit         m_rd_known = 1'b1;

   task frame_ok();
      m_done  = 1'b1;
      m_cnt   = m_cnt + 8'd1;
      m_phase = PH_DONE;
      m_ready = 1'b0;
      m_busy  = 1'b0;
   endtask

   task frame_abort();
      m_err   = 1'b1;
      m_phase = PH_HUNT;
      m_busy  = 1'b0;
   endtask

   task model_step();
      bit acc;
      acc    = in_valid && m_ready;
      m_done = 1'b0;
      m_err  = 1'b0;
      // read sees the memory as it was before this cycle's write
      if (int'(rd_addr) < DEPTH) begin
         m_rd_known = mknown[rd_addr];
         m_rd       = mram[rd_addr];
      end else begin
         m_rd_known = 1'b1;
         m_rd       = 8'h00;
      end
      if (m_phase == PH_DONE) begin
         m_phase = PH_HUNT;
         m_ready = 1'b1;
      end else if (acc) begin
         m_idle = 0;
         case (m_phase)
            PH_HUNT: if (in_data == 8'hA5) m_phase = PH_SYNC;
            PH_SYNC: begin
               if (in_data == 8'h5A) begin
                  m_phase = PH_PIX;
                  npix    = 0;
                  m_sum   = 8'h00;
                  m_busy  = 1'b1;
               end else if (in_data != 8'hA5) begin
                  m_phase = PH_HUNT;
               end
            end
            PH_PIX: begin
               mram[npix]   = in_data;
               mknown[npix] = 1'b1;
               m_sum        = m_sum + in_data;
               npix++;
               if (npix == DEPTH) begin
`ifdef FB_CHECKSUM_EN
                  m_phase = PH_SUM;
`else
                  frame_ok();
`endif
               end
            end
            PH_SUM: begin
               if (in_data == m_sum) frame_ok();
               else frame_abort();
            end
            default: m_phase = PH_HUNT;
         endcase
      end else if (m_phase == PH_PIX || m_phase == PH_SUM) begin
         if (m_idle == TMO - 1) begin
            frame_abort();
            m_idle = 0;
         end else begin
            m_idle++;
         end
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_phase = PH_HUNT; npix = 0; m_idle = 0;
         m_ready = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
         m_cnt = 8'h00; m_rd = 8'h00; m_rd_known = 1'b1;
      end else begin
         model_step();
      end
   end

   // ---------------- per-cycle compare and pulse counters ----------------
   int done_seen = 0;
   int err_seen  = 0;

   initial forever begin
      @(negedge clk);
      chk("in_ready", in_ready, m_ready);
      chk("load_busy", load_busy, m_busy);
      chk("load_done", load_done, m_done);
      chk("load_err", load_err, m_err);
      chk("frame_cnt", frame_cnt, m_cnt);
      if (m_rd_known) chk("rd_data", rd_data, m_rd);
      if (load_done === 1'b1) done_seen++;
      if (load_err === 1'b1) err_seen++;
   end

   // ---------------- stimulus ----------------
   bit rd_rand = 1'b1;
   logic [7:0] fr [DEPTH];

   initial forever begin
      @(posedge clk);
      #1;
      if (rd_rand) rd_addr = AW'($urandom_range(0, 8191));
   end

   task automatic send_byte(input logic [7:0] b, input int maxgap);
      int g;
      int tries;
      g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      if (g > 0) begin
         in_valid = 1'b0;
         repeat (g) begin @(posedge clk); #1; end
      end
      in_valid = 1'b1;
      in_data  = b;
      tries    = 0;
      forever begin
         @(negedge clk);
         if (in_ready === 1'b1) break;
         tries++;
         if (tries > 8) begin
            checks++;
            errors++;
            $display("FAIL handshake: in_ready stuck low for %0d cycles, expected 1", tries);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // kind 0: i[7:0], 1: all 8'h01, 2: random. trl 1: correct checksum, 2: wrong one.
   task automatic send_frame(input int kind, input int maxgap, input int trl);
      logic [7:0] s;
      s = 8'h00;
      for (int i = 0; i < DEPTH; i++) begin
         case (kind)
            0:       fr[i] = 8'(i);
            1:       fr[i] = 8'h01;
            default: fr[i] = 8'($urandom);
         endcase
         s = s + fr[i];
         send_byte(fr[i], maxgap);
      end
`ifdef FB_CHECKSUM_EN
      if (trl == 1) send_byte(s, maxgap);
      else if (trl == 2) send_byte(s + 8'd1, maxgap);
`else
      if (trl < 0) send_byte(s, maxgap);
`endif
   endtask

   task automatic rd_check(input string name, input int addr, input logic [7:0] exp);
      rd_rand = 1'b0;
      @(posedge clk);
      #2;
      rd_addr = AW'(addr);
      @(posedge clk);
      #2;
      chk(name, rd_data, exp);
      rd_rand = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int cyc;
      int d0;
      int e0;
      int expected_err;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset in_ready", in_ready, 1);
      chk("reset rd_data", rd_data, 0);
      chk("reset load_busy", load_busy, 0);
      chk("reset frame_cnt", frame_cnt, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(2);

      // 1: clean frame of i[7:0], back-to-back bytes
      send_byte(8'hA5, 0);
      send_byte(8'h5A, 0);
      send_frame(0, 0, 1);
      idle(4);
      chk("t1 done pulses", done_seen, 1);
      chk("t1 frame_cnt", frame_cnt, 1);
      rd_check("t1 rd 100", 100, 8'd100);
      rd_check("t5 rd 4799", 4799, 8'd191);
      rd_check("t5 rd 4800", 4800, 8'd0);
      rd_check("t5 rd 8191", 8191, 8'd0);

      // 2: repeated first header byte, random pixels with gaps
      send_byte(8'hA5, 1);
      send_byte(8'hA5, 1);
      send_byte(8'h5A, 1);
      send_frame(2, 2, 1);
      idle(4);
      chk("t2 frame_cnt", frame_cnt, 2);
      send_byte(8'h5A, 1);
      send_byte(8'h5A, 1);
      send_byte(8'hA5, 1);
      send_byte(8'h00, 1);
      idle(4);
      chk("t2 junk busy", load_busy, 0);
      chk("t2 junk frame_cnt", frame_cnt, 2);
      rd_check("t2 junk rd 0", 0, fr[0]);

      // 3: header, 10 bytes, then stall until timeout
      e0 = err_seen;
      send_byte(8'hA5, 0);
      send_byte(8'h5A, 0);
      for (int k = 0; k < 10; k++) send_byte(8'hE0 + 8'(k), 0);
      cyc = 0;
      while (cyc < TMO + 10) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (load_err === 1'b1) break;
      end
      chk("t3 err latency", cyc, TMO);
      idle(2);
      chk("t3 err pulses", err_seen - e0, 1);
      chk("t3 busy", load_busy, 0);
      chk("t3 frame_cnt", frame_cnt, 2);
      rd_check("t3 rd 0", 0, 8'hE0);
      rd_check("t3 rd 9", 9, 8'hE9);
      rd_check("t3 rd 10 old", 10, fr[10]);

      // 4: all-ones frame; checksum 4800 mod 256 = C0
      send_byte(8'hA5, 0);
      send_byte(8'h5A, 0);
      for (int i = 0; i < DEPTH; i++) begin fr[i] = 8'h01; send_byte(8'h01, 0); end
`ifdef FB_CHECKSUM_EN
      send_byte(8'hC0, 0);
`endif
      idle(4);
      chk("t4 frame_cnt", frame_cnt, 3);
      expected_err = 1;
`ifdef FB_CHECKSUM_EN
      send_byte(8'hA5, 0);
      send_byte(8'h5A, 0);
      for (int i = 0; i < DEPTH; i++) send_byte(8'h01, 0);
      send_byte(8'hC1, 0);
      idle(4);
      expected_err = 2;
      chk("t4 bad sum frame_cnt", frame_cnt, 3);
`endif
      chk("t4 err pulses", err_seen - e0, expected_err);

      // 6: reset in the middle of a frame, then a full frame
      d0 = done_seen;
      e0 = err_seen;
      send_byte(8'hA5, 1);
      send_byte(8'h5A, 1);
      for (int i = 0; i <= 2000; i++) send_byte(8'($urandom), 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t6 rst in_ready", in_ready, 1);
      chk("t6 rst busy", load_busy, 0);
      chk("t6 rst frame_cnt", frame_cnt, 0);
      chk("t6 rst rd_data", rd_data, 0);
      idle(3);
      rst_n = 1'b1;
      idle(3);
      chk("t6 no done pulse", done_seen - d0, 0);
      chk("t6 no err pulse", err_seen - e0, 0);
      send_byte(8'hA5, 1);
      send_byte(8'h5A, 1);
      send_frame(2, 1, 1);
      idle(4);
      chk("t6 frame_cnt", frame_cnt, 1);
      rd_check("t6 rd 2000", 2000, fr[2000]);
      rd_check("t6 rd 4799", 4799, fr[4799]);

      idle(5);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
